spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-002 SHALL have port clk, input, 1: single system clock; every flop is in this domain.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port ncs, input, 1: SPI chip select, active low, asynchronous to clk (top-level ui_in[2]).
REQ-005 SHALL have port copi, input, 1: SPI data in, asynchronous (ui_in[1]).
REQ-006 SHALL have port sclk, input, 1: SPI clock, asynchronous (ui_in[0]).
REQ-007 SHALL have port en_reg_out_7_0, output, 8: register at address 0x00.
REQ-008 SHALL have port en_reg_out_15_8, output, 8: register at address 0x01.
REQ-009 SHALL have port en_reg_pwm_7_0, output, 8: register at address 0x02.
REQ-010 SHALL have port en_reg_pwm_15_8, output, 8: register at address 0x03.
REQ-011 SHALL have port pwm_duty_cycle, output, 8: register at address 0x04.
REQ-012 SHALL have port wr_strobe, output, 1: one-cycle pulse on each committed write.

Function
REQ-013 SHALL pass ncs, sclk and copi each through a synchronizer of at least two flops, then through one edge-detect flop.
REQ-014 SHALL implement SPI mode 0: sample copi on each detected sclk rising edge while synchronized ncs is low, MSB first.
REQ-015 SHALL decode a frame as 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-016 SHALL implement an FSM with these states and transitions:
- IDLE -> SHIFT on ncs falling edge; clear shift register and bit counter.
- SHIFT -> COMMIT on ncs rising edge.
- COMMIT -> IDLE unconditionally after one cycle.
REQ-017 SHALL use a 5-bit bit counter that saturates at 16; further sclk edges set an overflow flag.
REQ-018 SHALL in COMMIT write data to the addressed register and pulse wr_strobe only if all of these hold: count == 16, no overflow, R/W == 1, address <= MAX_ADDR.
REQ-019 SHALL in COMMIT discard the frame silently, with registers unchanged and no strobe, if any condition in REQ-018 fails (short frame, long frame, read frame, out-of-range address).
REQ-020 SHALL give an ncs rising edge priority over an sclk edge detected in the same cycle; that sclk edge is not sampled.
REQ-021 SHALL ignore sclk edges while in IDLE or COMMIT.
REQ-022 SHALL, with two-stage synchronizers, show the written value on the output and assert wr_strobe exactly 4 clk rising edges after the ncs pin rise (setup met at edge 1).
REQ-023 SHALL hold each register value until it is overwritten or reset.
REQ-024 SHALL treat an ncs falling edge during COMMIT as the start of a new frame, taken once IDLE is reached on the next cycle.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force all five registers to 8'h00, wr_strobe to 0, the FSM to IDLE, the counter and shift register to 0, and the synchronizer flops to ncs = 1, sclk = 0, copi = 0.
REQ-026 SHALL abandon any frame in progress when reset asserts mid-frame; no partial write occurs.
REQ-027 SHALL NOT start a frame on release of reset while ncs is already low; a fresh ncs falling edge is required.

Configuration
REQ-028 SHALL, when macro SPI_SYNC3_EN is defined, use three-flop synchronizers; REQ-022 latency then becomes 5 edges.
REQ-029 SHALL, when SPI_SYNC3_EN is undefined, use two-flop synchronizers; function is otherwise identical in both builds.

Structure
REQ-030 SHALL take from shared package spi_pkg:
- register address constants ADDR_EN_OUT_LO/HI, ADDR_EN_PWM_LO/HI, ADDR_DUTY;
- FSM state typedef;
- FRAME_BITS = 16.
REQ-031 SHALL contain one sub-module, spi_sync, a single-bit synchronizer with edge-detect outputs (rise, fall), instantiated three times.

Verification
REQ-032 SHALL cover: write 0x8455 (addr 0x04, data 0x55), 2-stage build -> pwm_duty_cycle = 0x55 and wr_strobe high for exactly 1 cycle, 4 edges after ncs rise.
REQ-033 SHALL cover: frame 0x00AA (read bit = 0) -> all registers unchanged, no strobe.
REQ-034 SHALL cover: write 0x85FF (addr 0x05 > MAX_ADDR) -> no change, no strobe.
REQ-035 SHALL cover: 15-bit frame, then a 17-bit frame, each otherwise a write of 0xF0 to addr 0x00 -> en_reg_out_7_0 stays 0x00.
REQ-036 SHALL cover: rst_n pulsed low after 8 bits of 0x81CC -> registers 0x00; the next full frame 0x81CC sets en_reg_out_15_8 = 0xCC.
REQ-037 SHALL cover: SPI_SYNC3_EN build rerunning REQ-032 -> update occurs 5 edges after ncs rise.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI register peripheral.
// Defining SPI_SYNC3_EN switches the input synchronizers from two to three flops.
package spi_pkg;

`ifdef SPI_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef logic [1:0] spi_state_t;
    localparam spi_state_t ST_IDLE   = 2'd0;
    localparam spi_state_t ST_SHIFT  = 2'd1;
    localparam spi_state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer followed by an edge-detect flop.
// Emits the synchronized level plus one-cycle rise/fall pulses.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register file: 16-bit frames {wr, addr[6:0], data[7:0]}.
// Build option: SPI_SYNC3_EN selects three-flop input synchronizers.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter logic [6:0] MAX_ADDR = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ncs,
    input  logic       copi,
    input  logic       sclk,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    logic ncs_lvl, ncs_rise, ncs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

    spi_state_t            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [4:0]            bit_cnt;
    logic                  ovf;
    logic                  start_pend;
    logic                  armed;
    logic [SYNC_STAGES:0]  prime_pipe;
    logic                  start_req;
    logic                  frame_ok;

    // The ncs chain resets high, so a pin already low at reset release would look
    // like a falling edge. Only arm once the chain holds real samples showing ncs high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_pipe <= '0;
            armed      <= 1'b0;
        end else begin
            prime_pipe <= {prime_pipe[SYNC_STAGES-1:0], 1'b1};
            armed      <= armed | (prime_pipe[SYNC_STAGES] & ncs_lvl);
        end
    end

    assign start_req = armed & (ncs_fall | start_pend);
    assign frame_ok  = (bit_cnt == 5'(FRAME_BITS)) && !ovf && shreg[15] &&
                       (shreg[14:8] <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            ovf             <= 1'b0;
            start_pend      <= 1'b0;
            wr_strobe       <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state      <= ST_SHIFT;
                        shreg      <= '0;
                        bit_cnt    <= '0;
                        ovf        <= 1'b0;
                        start_pend <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // ncs rise wins; an sclk edge in the same cycle is dropped
                    if (ncs_rise) begin
                        state <= ST_COMMIT;
                    end else if (sclk_rise) begin
                        if (bit_cnt == 5'(FRAME_BITS)) begin
                            ovf <= 1'b1;
                        end else begin
                            shreg   <= {shreg[FRAME_BITS-2:0], copi_lvl};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (ncs_fall && armed) start_pend <= 1'b1;
                    if (frame_ok) begin
                        wr_strobe <= 1'b1;
                        case (shreg[14:8])
                            ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg[7:0];
                            ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg[7:0];
                            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg[7:0];
                            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg[7:0];
                            ADDR_DUTY:      pwm_duty_cycle  <= shreg[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Randomized self-checking bench for spi_peripheral against a frame-level register model.
// Honours SPI_SYNC3_EN for the expected commit latency.
module tb_spi_peripheral;

`ifdef SPI_SYNC3_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ncs = 1'b1;
    logic       copi = 1'b0;
    logic       sclk = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe;

    always #5 clk = ~clk;

    spi_peripheral #(.MAX_ADDR(7'h04)) dut (
        .clk(clk), .rst_n(rst_n), .ncs(ncs), .copi(copi), .sclk(sclk),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
    );

    int         n_tests = 0;
    int         n_fail = 0;
    int         strobe_cnt = 0;
    logic [7:0] mdl [5];

    always @(negedge clk) if (wr_strobe) strobe_cnt++;

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return en_reg_out_7_0;
            1: return en_reg_out_15_8;
            2: return en_reg_pwm_7_0;
            3: return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 5; i++) chk($sformatf("%s reg%0d", tag, i), dut_reg(i), mdl[i]);
    endtask

    // Drives n bits MSB first; ncs is left as the caller set it.
    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            repeat (3) @(negedge clk);
            sclk = 1'b1;
            repeat (3) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input string tag, input logic [31:0] bits, input int n);
        logic [15:0] f;
        bit          exp_wr;
        int          addr;
        int          c0;
        f = bits[15:0];
        addr = int'(f[14:8]);
        exp_wr = (n == 16) && f[15] && (addr <= 4);
        @(negedge clk);
        ncs = 1'b0;
        repeat (6) @(negedge clk);
        shift_bits(bits, n);
        c0 = strobe_cnt;
        ncs = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            @(posedge clk);
            #1;
            if (e == LAT - 1) begin
                chk({tag, " strobe early"}, wr_strobe, 0);
                if (exp_wr) chk({tag, " value early"}, dut_reg(addr), mdl[addr]);
            end
            if (e == LAT) begin
                chk({tag, " strobe"}, wr_strobe, exp_wr);
                if (exp_wr) chk({tag, " value"}, dut_reg(addr), f[7:0]);
            end
            if (e == LAT + 1) chk({tag, " strobe late"}, wr_strobe, 0);
        end
        if (exp_wr) mdl[addr] = f[7:0];
        repeat (4) @(posedge clk);
        #1;
        chk({tag, " strobe count"}, strobe_cnt - c0, exp_wr);
        check_all(tag);
    endtask

    initial begin
        int          len_tab [5] = '{15, 16, 16, 16, 17};
        logic [15:0] b16;
        logic [31:0] bits;
        int          n;
        int          c0;

        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset strobe", wr_strobe, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_frame("wr duty", 32'h8455, 16);
        send_frame("read frame", 32'h00AA, 16);
        send_frame("addr range", 32'h85FF, 16);
        send_frame("short", 32'h4078, 15);
        send_frame("long", 32'h101E0, 17);

        for (int k = 0; k < 40; k++) begin
            n = len_tab[$urandom_range(0, 4)];
            b16 = {($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
            if (n == 15) bits = 32'(b16 >> 1);
            else if (n == 17) bits = {15'd0, b16, 1'($urandom)};
            else bits = {16'd0, b16};
            send_frame($sformatf("rnd%0d", k), bits, n);
        end

        // reset mid-frame, then a frame that starts with ncs already low
        @(negedge clk);
        ncs = 1'b0;
        repeat (6) @(negedge clk);
        shift_bits(32'h81, 8);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_all("mid rst");
        chk("mid rst strobe", wr_strobe, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        c0 = strobe_cnt;
        shift_bits(32'h81CC, 16);
        ncs = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("no start strobe", strobe_cnt - c0, 0);
        check_all("no start");
        send_frame("after rst", 32'h81CC, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
